// File: rtl/ceespu_dmem_arbiter_if.sv
// ceespu_dmem_arbiter_if: CPU, DMA and shared data-RAM signals seen by the dmem arbiter
interface ceespu_dmem_arbiter_if;
  logic [15:0] I_cpuAddress;
  logic [31:0] I_cpuWData;
  logic        I_cpuE;
  logic [3:0]  I_cpuWe;
  logic [31:0] O_cpuRData;
  logic        O_cpuStall;
  logic        I_dmaReq;
  logic [15:0] I_dmaAddress;
  logic [31:0] I_dmaWData;
  logic [3:0]  I_dmaWe;
  logic        O_dmaGnt;
  logic        O_dmaRValid;
  logic [31:0] O_dmaRData;
  logic [15:0] O_dmemAddress;
  logic [31:0] O_dmemWData;
  logic        O_dmemE;
  logic [3:0]  O_dmemWe;
  logic [31:0] I_dmemData;
  modport master (
    input  I_cpuAddress, I_cpuWData, I_cpuE, I_cpuWe, I_dmaReq, I_dmaAddress, I_dmaWData, I_dmaWe, I_dmemData,
    output O_cpuRData, O_cpuStall, O_dmaGnt, O_dmaRValid, O_dmaRData, O_dmemAddress, O_dmemWData, O_dmemE, O_dmemWe
  );
  modport slave (
    output I_cpuAddress, I_cpuWData, I_cpuE, I_cpuWe, I_dmaReq, I_dmaAddress, I_dmaWData, I_dmaWe, I_dmemData,
    input  O_cpuRData, O_cpuStall, O_dmaGnt, O_dmaRValid, O_dmaRData, O_dmemAddress, O_dmemWData, O_dmemE, O_dmemWe
  );
endinterface

// File: rtl/ceespu_dmem_arbiter.sv
// ceespu_dmem_arbiter: shares one single-port data RAM between the CPU and a DMA/debug port,
// CPU first, with DMA forced through after MAX_WAIT consecutive denied cycles
module ceespu_dmem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input logic I_clk,
  input logic I_rst_n,
  ceespu_dmem_arbiter_if.master bus
);
  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_DMA} tag_t;
  tag_t        tag, tagNext;
  logic [3:0]  waitCnt, waitNext;
  logic [31:0] cpuHold;
  logic        forced, dmaOwn, cpuOwn;
  // reset gates ownership so the memory port is quiet while I_rst_n is low
  always_comb begin
    forced = waitCnt == 4'(MAX_WAIT);
    dmaOwn = I_rst_n && bus.I_dmaReq && (!bus.I_cpuE || forced);
    cpuOwn = I_rst_n && bus.I_cpuE && !dmaOwn;
    waitNext = (!bus.I_dmaReq || dmaOwn) ? 4'd0 : forced ? waitCnt : waitCnt + 4'd1;
    tagNext = (dmaOwn && bus.I_dmaWe == 4'd0) ? TAG_DMA : (cpuOwn && bus.I_cpuWe == 4'd0) ? TAG_CPU : TAG_NONE;
    bus.O_dmemE = dmaOwn || cpuOwn;
    bus.O_dmemAddress = dmaOwn ? bus.I_dmaAddress : cpuOwn ? bus.I_cpuAddress : 16'd0;
    bus.O_dmemWData = dmaOwn ? bus.I_dmaWData : cpuOwn ? bus.I_cpuWData : 32'd0;
    bus.O_dmemWe = dmaOwn ? bus.I_dmaWe : cpuOwn ? bus.I_cpuWe : 4'd0;
    bus.O_dmaGnt = dmaOwn;
    bus.O_cpuStall = bus.I_cpuE && dmaOwn;
    bus.O_dmaRValid = tag == TAG_DMA;
    bus.O_dmaRData = tag == TAG_DMA ? bus.I_dmemData : 32'd0;
    bus.O_cpuRData = tag == TAG_CPU ? bus.I_dmemData : cpuHold;
  end
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      waitCnt <= 4'd0;
      tag <= TAG_NONE;
      cpuHold <= 32'd0;
    end else begin
      waitCnt <= waitNext;
      tag <= tagNext;
      if (tag == TAG_CPU) cpuHold <= bus.I_dmemData;
    end
  end
endmodule

// File: tb/tb_ceespu_dmem_arbiter.sv
// tb_ceespu_dmem_arbiter: directed stimulus with an RAM fixture, a per-cycle reference model
// and hand-computed literal checks
module tb_ceespu_dmem_arbiter;
  localparam int MAX_WAIT = 4;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  logic [31:0] mem [0:1023];
  ceespu_dmem_arbiter_if bus();
  ceespu_dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (.I_clk(clk), .I_rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  // single-port synchronous RAM, read-before-write, one cycle read latency
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[10'h010] = 32'hDEADBEEF;
    mem[10'h020] = 32'h11223344;
    mem[10'h200] = 32'hCAFEF00D;
    bus.I_dmemData <= 32'd0;
    forever begin
      @(posedge clk);
      if (bus.O_dmemE) begin
        bus.I_dmemData <= mem[bus.O_dmemAddress[9:0]];
        for (int b = 0; b < 4; b++)
          if (bus.O_dmemWe[b]) mem[bus.O_dmemAddress[9:0]][8*b +: 8] = bus.O_dmemWData[8*b +: 8];
      end
    end
  end
  int mw = 0, nmw;
  int pend = 0, npend;
  logic [31:0] pendData = 32'd0, npData, held = 32'd0, nHeld;
  logic en, forced, dOwn, cOwn;
  logic [15:0] eAddr;
  initial forever begin
    @(negedge clk);
    en = rst_n;
    forced = mw == MAX_WAIT;
    dOwn = en && bus.I_dmaReq && (!bus.I_cpuE || forced);
    cOwn = en && bus.I_cpuE && !dOwn;
    eAddr = dOwn ? bus.I_dmaAddress : cOwn ? bus.I_cpuAddress : 16'h0;
    chk("m_dmemE", 32'(bus.O_dmemE), 32'(dOwn || cOwn));
    chk("m_addr", 32'(bus.O_dmemAddress), 32'(eAddr));
    chk("m_wdata", bus.O_dmemWData, dOwn ? bus.I_dmaWData : cOwn ? bus.I_cpuWData : 32'h0);
    chk("m_we", 32'(bus.O_dmemWe), 32'(dOwn ? bus.I_dmaWe : cOwn ? bus.I_cpuWe : 4'h0));
    chk("m_gnt", 32'(bus.O_dmaGnt), 32'(dOwn));
    chk("m_stall", 32'(bus.O_cpuStall), 32'(bus.I_cpuE && dOwn));
    chk("m_rvalid", 32'(bus.O_dmaRValid), 32'(pend == 2));
    chk("m_rdata", bus.O_dmaRData, pend == 2 ? pendData : 32'h0);
    chk("m_cpuRData", bus.O_cpuRData, pend == 1 ? pendData : held);
    nmw = (!bus.I_dmaReq || dOwn) ? 0 : forced ? mw : mw + 1;
    npend = (dOwn && bus.I_dmaWe == 4'h0) ? 2 : (cOwn && bus.I_cpuWe == 4'h0) ? 1 : 0;
    npData = mem[eAddr[9:0]];
    nHeld = pend == 1 ? pendData : held;
    @(posedge clk);
    if (!rst_n) begin
      mw = 0; pend = 0; pendData = 32'h0; held = 32'h0;
    end else begin
      mw = nmw; pend = npend; pendData = npData; held = nHeld;
    end
  end
  task automatic idle();
    bus.I_cpuE = 1'b0; bus.I_dmaReq = 1'b0; bus.I_cpuWe = 4'h0; bus.I_dmaWe = 4'h0;
  endtask
  task automatic nextCyc();
    @(posedge clk); #1;
  endtask
  task automatic mid();
    @(negedge clk); #1;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.I_cpuE = 1'b1; bus.I_cpuAddress = 16'h0010; bus.I_cpuWData = 32'h55; bus.I_cpuWe = 4'hF;
    bus.I_dmaReq = 1'b1; bus.I_dmaAddress = 16'h0200; bus.I_dmaWData = 32'h0; bus.I_dmaWe = 4'hF;
    mid();
    chk("rst_dmemE", 32'(bus.O_dmemE), 0);
    chk("rst_dmemWe", 32'(bus.O_dmemWe), 0);
    chk("rst_gnt", 32'(bus.O_dmaGnt), 0);
    chk("rst_stall", 32'(bus.O_cpuStall), 0);
    chk("rst_cpuRData", bus.O_cpuRData, 0);
    nextCyc(); nextCyc();
    rst_n = 1'b1; idle();
    nextCyc();
    bus.I_cpuE = 1'b1; bus.I_cpuAddress = 16'h0010; bus.I_cpuWe = 4'h0;
    mid();
    chk("cpurd_dmemE", 32'(bus.O_dmemE), 1);
    chk("cpurd_addr", 32'(bus.O_dmemAddress), 32'h10);
    chk("cpurd_stall", 32'(bus.O_cpuStall), 0);
    nextCyc(); idle(); mid();
    chk("cpurd_data", bus.O_cpuRData, 32'hDEADBEEF);
    nextCyc(); mid();
    chk("idle_dmemE", 32'(bus.O_dmemE), 0);
    chk("idle_dmemWe", 32'(bus.O_dmemWe), 0);
    chk("idle_hold", bus.O_cpuRData, 32'hDEADBEEF);
    nextCyc();
    bus.I_dmaReq = 1'b1; bus.I_dmaAddress = 16'h0100; bus.I_dmaWData = 32'h12345678; bus.I_dmaWe = 4'hF;
    mid();
    chk("dmawr_gnt", 32'(bus.O_dmaGnt), 1);
    chk("dmawr_we", 32'(bus.O_dmemWe), 32'hF);
    chk("dmawr_wdata", bus.O_dmemWData, 32'h12345678);
    nextCyc(); idle(); mid();
    chk("dmawr_norv", 32'(bus.O_dmaRValid), 0);
    nextCyc();
    bus.I_cpuE = 1'b1; bus.I_cpuAddress = 16'h0020; bus.I_cpuWData = 32'hAAAABBBB; bus.I_cpuWe = 4'h3;
    nextCyc();
    bus.I_cpuWe = 4'h0;
    nextCyc(); idle(); mid();
    chk("cpuwr_bytes", bus.O_cpuRData, 32'h1122BBBB);
    nextCyc();
    bus.I_cpuE = 1'b1; bus.I_cpuAddress = 16'h0010; bus.I_cpuWe = 4'h0;
    bus.I_dmaReq = 1'b1; bus.I_dmaAddress = 16'h0200; bus.I_dmaWe = 4'h0;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) bus.I_dmaReq = 1'b0;
      if (i == 6) bus.I_cpuE = 1'b0;
      mid();
      chk("cont_gnt", 32'(bus.O_dmaGnt), 32'(i == 4));
      chk("cont_stall", 32'(bus.O_cpuStall), 32'(i == 4));
      if (i < 6) chk("cont_addr", 32'(bus.O_dmemAddress), i == 4 ? 32'h200 : 32'h10);
      if (i == 5) begin
        chk("dmard_rv", 32'(bus.O_dmaRValid), 1);
        chk("dmard_data", bus.O_dmaRData, 32'hCAFEF00D);
      end
      if (i == 6) begin
        chk("dmard_rv_end", 32'(bus.O_dmaRValid), 0);
        chk("dmard_data_end", bus.O_dmaRData, 0);
      end
      nextCyc();
    end
    bus.I_dmaReq = 1'b1; bus.I_dmaAddress = 16'h0200; bus.I_dmaWe = 4'h0;
    mid();
    chk("rstrd_gnt", 32'(bus.O_dmaGnt), 1);
    #1 rst_n = 1'b0;
    nextCyc(); idle(); mid();
    chk("rstrd_rv", 32'(bus.O_dmaRValid), 0);
    chk("rstrd_data", bus.O_dmaRData, 0);
    chk("rstrd_dmemE", 32'(bus.O_dmemE), 0);
    nextCyc();
    rst_n = 1'b1;
    mid();
    chk("rstrd_rv_after", 32'(bus.O_dmaRValid), 0);
    nextCyc(); nextCyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
